// File: rtl/pcb_read_responder_if.sv
// pcb_read_responder_if: bundles every non-clock signal of the PCB read
// responder.
//   - Requester side: per-port line-read request/ack, shared returned line
//     with per-port valid strobes, and per-port bufid release request/ack.
//   - RAM read port: address, strobe and data.
//   - Free-bufid manager: bufid, write/ack handshake and the release counter.
// Signal names carry the direction as seen from the responder.
//   slave  : the responder (pcb_read_responder)
//   master : everything around it (ports, RAM, free manager)
interface pcb_read_responder_if;
    logic [15:0]  iv_pkt_raddr_p0;
    logic [15:0]  iv_pkt_raddr_p1;
    logic         i_pkt_rd_p0;
    logic         i_pkt_rd_p1;
    logic         o_pkt_raddr_ack_p0;
    logic         o_pkt_raddr_ack_p1;
    logic [133:0] ov_pkt_data;
    logic         o_pkt_data_wr_p0;
    logic         o_pkt_data_wr_p1;
    logic [8:0]   iv_pkt_bufid_p0;
    logic [8:0]   iv_pkt_bufid_p1;
    logic         i_pkt_bufid_wr_p0;
    logic         i_pkt_bufid_wr_p1;
    logic         o_pkt_bufid_ack_p0;
    logic         o_pkt_bufid_ack_p1;
    logic [15:0]  ov_ram_raddr;
    logic         o_ram_rd;
    logic [133:0] iv_ram_rdata;
    logic [8:0]   ov_free_bufid;
    logic         o_free_bufid_wr;
    logic         i_free_bufid_ack;
    logic [15:0]  ov_release_cnt;

    modport slave (
        input  iv_pkt_raddr_p0, iv_pkt_raddr_p1, i_pkt_rd_p0, i_pkt_rd_p1,
        output o_pkt_raddr_ack_p0, o_pkt_raddr_ack_p1,
        output ov_pkt_data, o_pkt_data_wr_p0, o_pkt_data_wr_p1,
        input  iv_pkt_bufid_p0, iv_pkt_bufid_p1, i_pkt_bufid_wr_p0, i_pkt_bufid_wr_p1,
        output o_pkt_bufid_ack_p0, o_pkt_bufid_ack_p1,
        output ov_ram_raddr, o_ram_rd,
        input  iv_ram_rdata,
        output ov_free_bufid, o_free_bufid_wr,
        input  i_free_bufid_ack,
        output ov_release_cnt
    );

    modport master (
        output iv_pkt_raddr_p0, iv_pkt_raddr_p1, i_pkt_rd_p0, i_pkt_rd_p1,
        input  o_pkt_raddr_ack_p0, o_pkt_raddr_ack_p1,
        input  ov_pkt_data, o_pkt_data_wr_p0, o_pkt_data_wr_p1,
        output iv_pkt_bufid_p0, iv_pkt_bufid_p1, i_pkt_bufid_wr_p0, i_pkt_bufid_wr_p1,
        input  o_pkt_bufid_ack_p0, o_pkt_bufid_ack_p1,
        input  ov_ram_raddr, o_ram_rd,
        output iv_ram_rdata,
        input  ov_free_bufid, o_free_bufid_wr,
        output i_free_bufid_ack,
        input  ov_release_cnt
    );
endinterface

// File: rtl/pcb_read_responder.sv
// pcb_read_responder: serving end of the PCB read / bufid-release interface.
// Round-robin arbitrates line reads from port 0 (host tx) and port 1 (network
// tx) onto the single PCB RAM read port and steers each returned 134-bit line
// back to its requester. Independently serializes bufid releases from both
// ports toward the free-bufid manager and counts completed releases.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      pcb_read_responder_if.slave (requesters, RAM read port, free manager)
// RD_LATENCY: cycles from o_ram_rd high to iv_ram_rdata valid (1..4).
module pcb_read_responder #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    pcb_read_responder_if.slave bus
);

    typedef enum logic [1:0] {RelIdle, RelWait, RelAck} rel_state_e;

    // ---------------- read path ----------------
    logic              ack_p0_q, ack_p1_q;
    logic              ram_rd_q;
    logic [15:0]       ram_raddr_q;
    logic              last_grant_q;
    logic              elig_p0, elig_p1, grant, grant_port;
    logic [RD_LATENCY:0] tag_valid_q, tag_port_q;
    logic [133:0]      pkt_data_q;
    logic              data_wr_p0_q, data_wr_p1_q;

    // A port still showing its ack this cycle is about to drop rd; do not regrant.
    assign elig_p0 = bus.i_pkt_rd_p0 & ~ack_p0_q;
    assign elig_p1 = bus.i_pkt_rd_p1 & ~ack_p1_q;
    assign grant   = elig_p0 | elig_p1;

    always_comb begin
        grant_port = elig_p1;
        if (elig_p0 && elig_p1) begin
            grant_port = ~last_grant_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_p0_q     <= 1'b0;
            ack_p1_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_raddr_q  <= '0;
            last_grant_q <= 1'b1;
            tag_valid_q  <= '0;
            tag_port_q   <= '0;
            pkt_data_q   <= '0;
            data_wr_p0_q <= 1'b0;
            data_wr_p1_q <= 1'b0;
        end else begin
            ram_rd_q <= grant;
            ack_p0_q <= grant & ~grant_port;
            ack_p1_q <= grant & grant_port;
            if (grant) begin
                ram_raddr_q  <= grant_port ? bus.iv_pkt_raddr_p1 : bus.iv_pkt_raddr_p0;
                last_grant_q <= grant_port;
            end
            // Tag stage i is live in the (i+1)th cycle after the grant edge, so
            // the last stage lines up with RAM data becoming valid.
            tag_valid_q  <= {tag_valid_q[RD_LATENCY-1:0], grant};
            tag_port_q   <= {tag_port_q[RD_LATENCY-1:0], grant & grant_port};
            data_wr_p0_q <= tag_valid_q[RD_LATENCY] & ~tag_port_q[RD_LATENCY];
            data_wr_p1_q <= tag_valid_q[RD_LATENCY] & tag_port_q[RD_LATENCY];
            if (tag_valid_q[RD_LATENCY]) begin
                pkt_data_q <= bus.iv_ram_rdata;
            end
        end
    end

    assign bus.o_pkt_raddr_ack_p0 = ack_p0_q;
    assign bus.o_pkt_raddr_ack_p1 = ack_p1_q;
    assign bus.o_ram_rd           = ram_rd_q;
    assign bus.ov_ram_raddr       = ram_raddr_q;
    assign bus.ov_pkt_data        = pkt_data_q;
    assign bus.o_pkt_data_wr_p0   = data_wr_p0_q;
    assign bus.o_pkt_data_wr_p1   = data_wr_p1_q;

    // ---------------- release path ----------------
    rel_state_e   rel_state_q;
    logic         rel_last_q;
    logic         rel_sel;
    logic [8:0]   free_bufid_q;
    logic         free_wr_q;
    logic [15:0]  release_cnt_q;
    logic         bufid_ack_p0_q, bufid_ack_p1_q;

    always_comb begin
        rel_sel = bus.i_pkt_bufid_wr_p1;
        if (bus.i_pkt_bufid_wr_p0 && bus.i_pkt_bufid_wr_p1) begin
            rel_sel = ~rel_last_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rel_state_q    <= RelIdle;
            rel_last_q     <= 1'b1;
            free_bufid_q   <= '0;
            free_wr_q      <= 1'b0;
            release_cnt_q  <= '0;
            bufid_ack_p0_q <= 1'b0;
            bufid_ack_p1_q <= 1'b0;
        end else begin
            case (rel_state_q)
                RelIdle: begin
                    if (bus.i_pkt_bufid_wr_p0 || bus.i_pkt_bufid_wr_p1) begin
                        rel_last_q   <= rel_sel;
                        free_bufid_q <= rel_sel ? bus.iv_pkt_bufid_p1 : bus.iv_pkt_bufid_p0;
                        free_wr_q    <= 1'b1;
                        rel_state_q  <= RelWait;
                    end
                end
                RelWait: begin
                    if (bus.i_free_bufid_ack) begin
                        free_wr_q      <= 1'b0;
                        release_cnt_q  <= release_cnt_q + 16'd1;
                        // rel_last_q still names the port being served.
                        bufid_ack_p0_q <= ~rel_last_q;
                        bufid_ack_p1_q <= rel_last_q;
                        rel_state_q    <= RelAck;
                    end
                end
                RelAck: begin
                    bufid_ack_p0_q <= 1'b0;
                    bufid_ack_p1_q <= 1'b0;
                    rel_state_q    <= RelIdle;
                end
                default: begin
                    rel_state_q <= RelIdle;
                end
            endcase
        end
    end

    assign bus.ov_free_bufid      = free_bufid_q;
    assign bus.o_free_bufid_wr    = free_wr_q;
    assign bus.ov_release_cnt     = release_cnt_q;
    assign bus.o_pkt_bufid_ack_p0 = bufid_ack_p0_q;
    assign bus.o_pkt_bufid_ack_p1 = bufid_ack_p1_q;

endmodule

// File: tb/tb_pcb_read_responder.sv
module tb_pcb_read_responder;
    localparam int unsigned RD_LATENCY = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcb_read_responder_if bus ();

    pcb_read_responder #(.RD_LATENCY(RD_LATENCY)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Line content is a fixed function of the address so expected data is known.
    function automatic logic [133:0] ram_word(input logic [15:0] a);
        return {{8{a}}, a[5:0]} ^ {67{2'b01}};
    endfunction

    // RAM model: data valid RD_LATENCY cycles after the read strobe.
    logic [133:0] ram_pipe [RD_LATENCY];
    always @(posedge clk) begin
        ram_pipe[0] <= bus.o_ram_rd ? ram_word(bus.ov_ram_raddr) : '0;
        for (int i = 1; i < RD_LATENCY; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign bus.iv_ram_rdata = ram_pipe[RD_LATENCY-1];

    typedef struct {
        logic [2:0]  drv;    // {rst_n, rd_p0, rd_p1} driven for the coming edge
        logic [15:0] a0;
        logic [15:0] a1;
        logic [2:0]  acks;   // expected {ack_p0, ack_p1, ram_rd} this cycle
        logic [15:0] raddr;  // checked when ram_rd expected
        logic [1:0]  wr;     // expected {data_wr_p0, data_wr_p1}
        logic [15:0] daddr;  // address whose line is expected on ov_pkt_data
        logic        zero;   // also expect ov_pkt_data and ov_ram_raddr to be 0
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    vec_t         v;
    logic         bad;
    logic [133:0] want_data;

    initial begin
        bus.iv_pkt_raddr_p0   = '0;
        bus.iv_pkt_raddr_p1   = '0;
        bus.i_pkt_rd_p0       = 1'b0;
        bus.i_pkt_rd_p1       = 1'b0;
        bus.iv_pkt_bufid_p0   = '0;
        bus.iv_pkt_bufid_p1   = '0;
        bus.i_pkt_bufid_wr_p0 = 1'b0;
        bus.i_pkt_bufid_wr_p1 = 1'b0;
        bus.i_free_bufid_ack  = 1'b0;

        // ---- read-path vectors ----
        // single port-0 read of 0x0A05
        vecs.push_back(vec_t'{3'b110, 16'h0A05, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b1});
        vecs.push_back(vec_t'{3'b100, 16'h0A05, 16'h0000, 3'b101, 16'h0A05, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b10, 16'h0A05, 1'b0});
        vecs.push_back(vec_t'{3'b000, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b1});
        // both ports requesting continuously: strict alternation from p0
        vecs.push_back(vec_t'{3'b111, 16'h0100, 16'h0200, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b111, 16'h0101, 16'h0200, 3'b101, 16'h0100, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b111, 16'h0101, 16'h0201, 3'b011, 16'h0200, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b111, 16'h0102, 16'h0201, 3'b101, 16'h0101, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b111, 16'h0102, 16'h0202, 3'b011, 16'h0201, 2'b10, 16'h0100, 1'b0});
        vecs.push_back(vec_t'{3'b111, 16'h0103, 16'h0202, 3'b101, 16'h0102, 2'b01, 16'h0200, 1'b0});
        vecs.push_back(vec_t'{3'b111, 16'h0103, 16'h0203, 3'b011, 16'h0202, 2'b10, 16'h0101, 1'b0});
        vecs.push_back(vec_t'{3'b101, 16'h0103, 16'h0203, 3'b101, 16'h0103, 2'b01, 16'h0201, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0103, 16'h0203, 3'b011, 16'h0203, 2'b10, 16'h0102, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b01, 16'h0202, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b10, 16'h0103, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b01, 16'h0203, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        // reset one cycle after a p0 grant: tag dropped, next tie goes to p0
        vecs.push_back(vec_t'{3'b110, 16'h0333, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b000, 16'h0000, 16'h0000, 3'b101, 16'h0333, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b1});
        vecs.push_back(vec_t'{3'b111, 16'h0444, 16'h0555, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b101, 16'h0444, 16'h0555, 3'b101, 16'h0444, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b011, 16'h0555, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b10, 16'h0444, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b01, 16'h0555, 1'b0});
        vecs.push_back(vec_t'{3'b100, 16'h0000, 16'h0000, 3'b000, 16'h0000, 2'b00, 16'h0000, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- reset state ----
        chk1 ("rst_ack_p0",     bus.o_pkt_raddr_ack_p0, 1'b0);
        chk1 ("rst_ack_p1",     bus.o_pkt_raddr_ack_p1, 1'b0);
        chk1 ("rst_ram_rd",     bus.o_ram_rd,           1'b0);
        chk1 ("rst_data_wr_p0", bus.o_pkt_data_wr_p0,   1'b0);
        chk1 ("rst_data_wr_p1", bus.o_pkt_data_wr_p1,   1'b0);
        chk1 ("rst_free_wr",    bus.o_free_bufid_wr,    1'b0);
        chk1 ("rst_bufid_ack0", bus.o_pkt_bufid_ack_p0, 1'b0);
        chk1 ("rst_bufid_ack1", bus.o_pkt_bufid_ack_p1, 1'b0);
        chk16("rst_free_bufid", 16'(bus.ov_free_bufid), 16'h0000);
        chk16("rst_release_cnt", bus.ov_release_cnt,    16'h0000);

        // ---- table-driven read path ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            want_data = v.zero ? '0 : ram_word(v.daddr);
            bad = ({bus.o_pkt_raddr_ack_p0, bus.o_pkt_raddr_ack_p1, bus.o_ram_rd} !== v.acks) ||
                  ({bus.o_pkt_data_wr_p0, bus.o_pkt_data_wr_p1} !== v.wr);
            if (v.acks[0] && bus.ov_ram_raddr !== v.raddr) bad = 1'b1;
            if (v.wr != 2'b00 && bus.ov_pkt_data !== want_data) bad = 1'b1;
            if (v.zero && (bus.ov_pkt_data !== '0 || bus.ov_ram_raddr !== 16'h0000)) bad = 1'b1;
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL vec%0d: ack0,ack1,rd=%b raddr=%h wr=%b data=%h; want %b raddr=%h wr=%b data=%h",
                         i, {bus.o_pkt_raddr_ack_p0, bus.o_pkt_raddr_ack_p1, bus.o_ram_rd},
                         bus.ov_ram_raddr, {bus.o_pkt_data_wr_p0, bus.o_pkt_data_wr_p1},
                         bus.ov_pkt_data, v.acks, v.raddr, v.wr, want_data);
            end
            rst_n               = v.drv[2];
            bus.i_pkt_rd_p0     = v.drv[1];
            bus.i_pkt_rd_p1     = v.drv[0];
            bus.iv_pkt_raddr_p0 = v.a0;
            bus.iv_pkt_raddr_p1 = v.a1;
        end

        // ---- port 1 releases 0x1FF, manager acks after 3 cycles ----
        @(negedge clk);
        bus.iv_pkt_bufid_p1   = 9'h1FF;
        bus.i_pkt_bufid_wr_p1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1 ("rel1_free_wr", bus.o_free_bufid_wr, 1'b1);
            chk16("rel1_bufid",   16'(bus.ov_free_bufid), 16'h01FF);
            chk1 ("rel1_no_ack",  bus.o_pkt_bufid_ack_p1, 1'b0);
        end
        bus.i_free_bufid_ack = 1'b1;
        @(negedge clk);
        bus.i_free_bufid_ack = 1'b0;
        chk1 ("rel1_free_wr_off", bus.o_free_bufid_wr,    1'b0);
        chk1 ("rel1_ack_p1",      bus.o_pkt_bufid_ack_p1, 1'b1);
        chk1 ("rel1_ack_p0",      bus.o_pkt_bufid_ack_p0, 1'b0);
        chk16("rel1_cnt",         bus.ov_release_cnt,     16'h0001);
        bus.i_pkt_bufid_wr_p1 = 1'b0;
        @(negedge clk);
        chk1 ("rel1_ack_p1_once", bus.o_pkt_bufid_ack_p1, 1'b0);
        @(negedge clk);
        chk1 ("rel1_no_restart",  bus.o_free_bufid_wr,    1'b0);

        // ---- both ports release together (7, 9), ack tied high ----
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.iv_pkt_bufid_p0   = 9'd7;
        bus.iv_pkt_bufid_p1   = 9'd9;
        bus.i_pkt_bufid_wr_p0 = 1'b1;
        bus.i_pkt_bufid_wr_p1 = 1'b1;
        bus.i_free_bufid_ack  = 1'b1;
        @(negedge clk);
        chk1 ("rel2_wr_a",    bus.o_free_bufid_wr, 1'b1);
        chk16("rel2_bufid_a", 16'(bus.ov_free_bufid), 16'h0007);
        @(negedge clk);
        chk1 ("rel2_ack_p0",  bus.o_pkt_bufid_ack_p0, 1'b1);
        chk1 ("rel2_ack_p1a", bus.o_pkt_bufid_ack_p1, 1'b0);
        chk16("rel2_cnt_a",   bus.ov_release_cnt, 16'h0001);
        bus.i_pkt_bufid_wr_p0 = 1'b0;
        @(negedge clk);
        chk1 ("rel2_gap",     bus.o_free_bufid_wr, 1'b0);
        @(negedge clk);
        chk1 ("rel2_wr_b",    bus.o_free_bufid_wr, 1'b1);
        chk16("rel2_bufid_b", 16'(bus.ov_free_bufid), 16'h0009);
        @(negedge clk);
        chk1 ("rel2_ack_p1",  bus.o_pkt_bufid_ack_p1, 1'b1);
        chk1 ("rel2_ack_p0b", bus.o_pkt_bufid_ack_p0, 1'b0);
        chk16("rel2_cnt_b",   bus.ov_release_cnt, 16'h0002);
        bus.i_pkt_bufid_wr_p1 = 1'b0;
        @(negedge clk);
        chk1 ("rel2_idle",    bus.o_free_bufid_wr, 1'b0);
        chk16("rel2_cnt_c",   bus.ov_release_cnt, 16'h0002);
        bus.i_free_bufid_ack = 1'b0;

        // ---- counter wrap: preload 0xFFFF, then one more release ----
        force dut.release_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.release_cnt_q;
        @(negedge clk);
        chk16("wrap_preload", bus.ov_release_cnt, 16'hFFFF);
        bus.iv_pkt_bufid_p0   = 9'h123;
        bus.i_pkt_bufid_wr_p0 = 1'b1;
        bus.i_free_bufid_ack  = 1'b1;
        @(negedge clk);
        chk16("wrap_bufid",   16'(bus.ov_free_bufid), 16'h0123);
        @(negedge clk);
        chk1 ("wrap_ack_p0",  bus.o_pkt_bufid_ack_p0, 1'b1);
        chk16("wrap_cnt",     bus.ov_release_cnt, 16'h0000);
        bus.i_pkt_bufid_wr_p0 = 1'b0;
        bus.i_free_bufid_ack  = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
